// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared constants and types for the MIPS pipeline forwarding and
//           hazard logic.
//           - REG_ZERO                : hard-wired zero register address
//           - NB_REG_ADDR_DEF/NB_REG_DEF : default register address/data widths
//           - STG_EX/STG_MEM/STG_WB   : forwarding stage indices, youngest first
//           - mc_state_e              : multi-cycle tracker state
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int NB_REG_ADDR_DEF = 5;
  localparam int NB_REG_DEF      = 32;

  // Register 0 always reads as zero, so it never creates a dependency.
  localparam int REG_ZERO = 0;

  // Forwarding stage indices. A lower index is a younger stage and wins.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef enum logic [0:0] {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : fwd_select
// Purpose : Priority match-and-mux for one source operand over N_STAGES
//           forwarding sources. The lowest-index (youngest) matching stage
//           wins.
// Ports   : i_addr      operand register address
//           i_used      operand is actually read
//           i_fwd_we    per-stage write enable
//           i_fwd_addr  per-stage destination register (packed)
//           i_fwd_data  per-stage result (packed)
//           i_fwd_rdy   per-stage result valid now
//           o_hit       some stage matched
//           o_data      winning stage data, 0 when there is no hit
//           o_rdy       winning stage readiness, 1 when there is no hit
// Revision: 1.0 - initial release
// ============================================================================
module fwd_select
  import mips_pkg::*;
#(
  parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
  parameter int NB_REG      = NB_REG_DEF,
  parameter int N_STAGES    = 3
) (
  input  logic [NB_REG_ADDR-1:0]          i_addr,
  input  logic                            i_used,
  input  logic [N_STAGES-1:0]             i_fwd_we,
  input  logic [N_STAGES*NB_REG_ADDR-1:0] i_fwd_addr,
  input  logic [N_STAGES*NB_REG-1:0]      i_fwd_data,
  input  logic [N_STAGES-1:0]             i_fwd_rdy,
  output logic                            o_hit,
  output logic [NB_REG-1:0]               o_data,
  output logic                            o_rdy
);

  localparam logic [NB_REG_ADDR-1:0] C_ZERO = NB_REG_ADDR'(REG_ZERO);

  // Scan oldest to youngest so the youngest match is assigned last and wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    o_rdy  = 1'b1;
    for (int s = N_STAGES - 1; s >= STG_EX; s--) begin
      if (i_used && i_fwd_we[s] && (i_addr != C_ZERO) &&
          (i_fwd_addr[s*NB_REG_ADDR +: NB_REG_ADDR] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_fwd_data[s*NB_REG +: NB_REG];
        o_rdy  = i_fwd_rdy[s];
      end
    end
  end

endmodule : fwd_select
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : forward_hazard_unit
// Purpose : Operand forwarding and hazard detection beside the ID/EX boundary.
//           Resolves N_SRC operands against N_STAGES write-back sources,
//           stalls on load-use and on reads of an in-flight multi-cycle
//           result, counts stall cycles and flags protocol errors.
// Ports   : i_clock/i_reset  clock (rising) / async active-low reset
//           i_valid          ID holds a valid instruction
//           i_src_addr/used  operand addresses and usage
//           i_fwd_we/addr/data/rdy  per-stage forwarding sources
//           i_mc_start/rd/lat       multi-cycle op issue
//           o_data/o_fwd     forwarded data and select per operand
//           o_stall          hold PC and IF/ID, bubble into EX
//           o_mc_busy        multi-cycle op pending
//           o_stall_cnt      saturating stall-cycle count
//           o_err            sticky: i_mc_start seen while busy
// Revision: 1.0 - initial release
// ============================================================================
module forward_hazard_unit
  import mips_pkg::*;
#(
  parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
  parameter int NB_REG      = NB_REG_DEF,
  parameter int N_SRC       = 2,
  parameter int N_STAGES    = 3,
  parameter int NB_LAT      = 4,
  parameter int NB_STALLCNT = 16
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_valid,
  input  logic [N_SRC*NB_REG_ADDR-1:0]    i_src_addr,
  input  logic [N_SRC-1:0]                i_src_used,
  input  logic [N_STAGES-1:0]             i_fwd_we,
  input  logic [N_STAGES*NB_REG_ADDR-1:0] i_fwd_addr,
  input  logic [N_STAGES*NB_REG-1:0]      i_fwd_data,
  input  logic [N_STAGES-1:0]             i_fwd_rdy,
  input  logic                            i_mc_start,
  input  logic [NB_REG_ADDR-1:0]          i_mc_rd,
  input  logic [NB_LAT-1:0]               i_mc_lat,
  output logic [N_SRC*NB_REG-1:0]         o_data,
  output logic [N_SRC-1:0]                o_fwd,
  output logic                            o_stall,
  output logic                            o_mc_busy,
  output logic [NB_STALLCNT-1:0]          o_stall_cnt,
  output logic                            o_err
);

  localparam logic [NB_REG_ADDR-1:0] C_ZERO    = NB_REG_ADDR'(REG_ZERO);
  localparam logic [NB_LAT-1:0]      C_LAT_ONE = NB_LAT'(1);

  // --------------------------------------------------------------------------
  // Per-operand forwarding
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0] src_hit;
  logic [N_SRC-1:0] src_rdy;

  generate
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
      fwd_select #(
        .NB_REG_ADDR (NB_REG_ADDR),
        .NB_REG      (NB_REG),
        .N_STAGES    (N_STAGES)
      ) u_fwd_select (
        .i_addr     (i_src_addr[k*NB_REG_ADDR +: NB_REG_ADDR]),
        .i_used     (i_src_used[k]),
        .i_fwd_we   (i_fwd_we),
        .i_fwd_addr (i_fwd_addr),
        .i_fwd_data (i_fwd_data),
        .i_fwd_rdy  (i_fwd_rdy),
        .o_hit      (src_hit[k]),
        .o_data     (o_data[k*NB_REG +: NB_REG]),
        .o_rdy      (src_rdy[k])
      );
    end
  endgenerate

  assign o_fwd = src_hit;

  // A winning stage that is not ready is a load still in flight; an older
  // ready stage would hold stale data, so the operand must wait.
  logic load_use;
  assign load_use = |(src_hit & ~src_rdy);

  // --------------------------------------------------------------------------
  // Multi-cycle op tracker
  // --------------------------------------------------------------------------
  mc_state_e                state_q, state_d;
  logic [NB_LAT-1:0]        cnt_q, cnt_d;
  logic [NB_REG_ADDR-1:0]   rd_q, rd_d;
  logic                     err_q, err_d;
  logic [NB_STALLCNT-1:0]   stall_cnt_q, stall_cnt_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= MC_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      MC_IDLE: begin
        if (i_mc_start) begin
          state_d = MC_BUSY;
          // A zero latency still occupies the unit for one cycle.
          cnt_d   = (i_mc_lat == '0) ? C_LAT_ONE : i_mc_lat;
          rd_d    = i_mc_rd;
        end
      end
      MC_BUSY: begin
        if (i_mc_start) begin
          err_d = 1'b1;
        end
        if (cnt_q == C_LAT_ONE) begin
          state_d = MC_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - C_LAT_ONE;
        end
      end
      default: begin
        state_d = MC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_mc_busy = (state_q == MC_BUSY);
  assign o_err     = err_q;

  // --------------------------------------------------------------------------
  // Stall combine
  // --------------------------------------------------------------------------
  logic mc_raw;
  always_comb begin
    mc_raw = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_src_used[k] && (rd_q != C_ZERO) &&
          (i_src_addr[k*NB_REG_ADDR +: NB_REG_ADDR] == rd_q)) begin
        mc_raw = 1'b1;
      end
    end
  end

  // A second issue while busy is also a structural conflict on the unit.
  logic mc_hazard;
  assign mc_hazard = o_mc_busy & (mc_raw | i_mc_start);

  assign o_stall = i_valid & (load_use | mc_hazard);

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + NB_STALLCNT'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule : forward_hazard_unit
`default_nettype wire
